// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one multi-cycle arithmetic unit between two requesters.
// Round-robin grant in IDLE, start pulse in ISSUE, done/timeout in WAIT,
// and a valid/ready response back to the granted requester in RESP.
module alu_scheduler #(
    parameter int OP_W    = 4,
    parameter int RES_W   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OP_W-1:0]  req0_a,
    input  logic [OP_W-1:0]  req0_b,
    input  logic [2:0]       req0_opcode,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OP_W-1:0]  req1_a,
    input  logic [OP_W-1:0]  req1_b,
    input  logic [2:0]       req1_opcode,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [RES_W-1:0] rsp_data,
    output logic             rsp_err,

    output logic [OP_W-1:0]  alu_a,
    output logic [OP_W-1:0]  alu_b,
    output logic [2:0]       alu_opcode,
    output logic             alu_start,
    input  logic [RES_W-1:0] alu_result,
    input  logic             alu_done,

    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    // TIMEOUT is at most 255, so an 8-bit counter always suffices.
    localparam int               CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       OP_LAST  = 3'b101;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               grant_q, grant_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [RES_W-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               armed_q, armed_d;

    logic               win_any;
    logic               win_idx;
    logic [OP_W-1:0]    sel_a;
    logic [OP_W-1:0]    sel_b;
    logic [2:0]         sel_op;
    logic               accept;
    logic               rsp_take;

    // Round-robin winner among the requesters that are currently valid.
    always_comb begin
        win_any = req0_valid | req1_valid;
        win_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            win_idx = ~last_grant_q;
        end else if (req1_valid) begin
            win_idx = 1'b1;
        end
        sel_a  = win_idx ? req1_a      : req0_a;
        sel_b  = win_idx ? req1_b      : req0_b;
        sel_op = win_idx ? req1_opcode : req0_opcode;
    end

    // Request handshake: only the winner sees ready, only in IDLE.
    // armed_q keeps both readies low while reset is held (state alone is IDLE then).
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (armed_q && (state_q == S_IDLE) && win_any) begin
            req0_ready = ~win_idx;
            req1_ready =  win_idx;
        end
        accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        rsp_take = grant_q ? rsp1_ready : rsp0_ready;
    end

    // Next-state and captured-data logic for the scheduling FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        data_d       = data_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        armed_d      = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d = win_idx;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    op_d    = sel_op;
                    if (sel_op > OP_LAST) begin
                        // Unsupported opcode: answer with an error, never start the unit.
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Compare the incremented count so the response lands exactly
                // TIMEOUT cycles after the start pulse.
                cnt_d = cnt_q + 1'b1;
                if (alu_done) begin
                    data_d  = alu_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_d == CNT_LAST) begin
                    data_d  = '1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (rsp_take) begin
                    last_grant_d = grant_q;
                    state_d      = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; async active-low reset abandons any request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            data_q       <= data_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        alu_start  = (state_q == S_ISSUE);
        rsp0_valid = (state_q == S_RESP) && !grant_q;
        rsp1_valid = (state_q == S_RESP) &&  grant_q;
        busy       = (state_q != S_IDLE);
        alu_a      = a_q;
        alu_b      = b_q;
        alu_opcode = op_q;
        rsp_data   = data_q;
        rsp_err    = err_q;
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: behavioural ALU model plus a
// scoreboard of expected responses, one task per scenario.
module tb_alu_scheduler;

    logic       clk;
    logic       reset;
    logic       req0_valid, req0_ready;
    logic [3:0] req0_a, req0_b;
    logic [2:0] req0_opcode;
    logic       req1_valid, req1_ready;
    logic [3:0] req1_a, req1_b;
    logic [2:0] req1_opcode;
    logic       rsp0_valid, rsp0_ready;
    logic       rsp1_valid, rsp1_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic       alu_start;
    logic [7:0] alu_result;
    logic       alu_done;
    logic       busy;

    typedef struct packed {
        logic       idx;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];

    int   errors      = 0;
    int   checks      = 0;
    int   alu_delay   = 1;
    bit   alu_hang    = 1'b0;
    int   poke_req    = 0;
    int   poke_ack    = 0;
    int   start_count = 0;
    int   m_cnt       = 0;
    logic [7:0] m_res;

    alu_scheduler #(.OP_W(4), .RES_W(8), .TIMEOUT(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_opcode(req0_opcode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_opcode(req1_opcode),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_start(alu_start), .alu_result(alu_result), .alu_done(alu_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic: 000 add, 001 sub, 010 div, 011 mul, 100 pow, 101 percent.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [7:0]  wa, wb, r;
        logic [15:0] p;
        wa = {4'b0, a};
        wb = {4'b0, b};
        p  = {8'b0, wa} * {8'b0, wb};
        case (op)
            3'd0: r = wa + wb;
            3'd1: r = wa - wb;
            3'd2: r = (wb == 8'd0) ? 8'hFF : wa / wb;
            3'd3: r = wa * wb;
            3'd4: begin
                r = 8'd1;
                for (int unsigned i = 0; i < 32'(b); i++) r = r * wa;
            end
            3'd5: r = 8'(p / 16'd100);
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    // ALU model: done alu_delay cycles after start (never if alu_hang); extra pokes on request.
    initial begin
        alu_done   = 1'b0;
        alu_result = 8'd0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                m_cnt = 0;
            end else if (alu_start === 1'b1) begin
                start_count++;
                m_res = alu_ref(alu_a, alu_b, alu_opcode);
                m_cnt = alu_hang ? 0 : alu_delay;
            end
            @(posedge clk);
            #1;
            alu_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    alu_done   = 1'b1;
                    alu_result = m_res;
                end
            end
            if (poke_req != poke_ack) begin
                poke_ack   = poke_req;
                alu_done   = 1'b1;
                alu_result = 8'h5A;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at a drive point; returns at the negedge of the accepting cycle.
    task automatic wait_accept_any(input int limit, output int who, output int cyc);
        who = -1;
        cyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (i > 0) step();
            @(negedge clk);
            if (req0_valid && req0_ready) begin who = 0; cyc = i; return; end
            if (req1_valid && req1_ready) begin who = 1; cyc = i; return; end
        end
    endtask

    // Called at a drive point; returns at the negedge of the first response cycle.
    task automatic wait_rsp_any(input int limit, output int who, output int cyc);
        who = -1;
        cyc = -1;
        for (int i = 0; i < limit; i++) begin
            if (i > 0) step();
            @(negedge clk);
            if (rsp0_valid === 1'b1) begin who = 0; cyc = i; return; end
            if (rsp1_valid === 1'b1) begin who = 1; cyc = i; return; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd0; req0_b = 4'd0; req0_opcode = 3'd0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_opcode = 3'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_start, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_start, busy});
        end
        checks++;
        if (rsp_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 00", rsp_data);
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode} !== 11'd0) begin
            errors++;
            $display("FAIL reset_alu: got a=%h b=%h op=%h, required 0", alu_a, alu_b, alu_opcode);
        end
        step();
        reset = 1'b1;
        req0_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_single();
        int who, cyc;
        exp_t e, act;
        alu_hang = 1'b0; alu_delay = 1;
        req0_a = 4'd3; req0_b = 4'd4; req0_opcode = 3'b011; req0_valid = 1'b1;
        wait_accept_any(10, who, cyc);
        checks++;
        if (who !== 0 || cyc !== 0) begin
            errors++;
            $display("FAIL single_accept: who=%0d cycle=%0d, required who=0 cycle=0", who, cyc);
        end
        e.idx = 1'b0; e.data = alu_ref(4'd3, 4'd4, 3'b011); e.err = 1'b0;
        sb.push_back(e);
        step();
        @(negedge clk);
        checks++;
        if ({alu_start, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_start: start=%b ready=%b, required start=1 ready=0", alu_start, req0_ready);
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode} !== {4'd3, 4'd4, 3'b011}) begin
            errors++;
            $display("FAIL single_operands: got a=%0d b=%0d op=%b, required 3 4 011", alu_a, alu_b, alu_opcode);
        end
        step();
        req0_valid = 1'b0;
        wait_rsp_any(20, who, cyc);
        checks++;
        if (who !== 0 || cyc !== 1) begin
            errors++;
            $display("FAIL single_latency: who=%0d offset=%0d, required who=0 offset=1", who, cyc);
        end
        checks++;
        if ({rsp_data, rsp_err} !== {8'd12, 1'b0}) begin
            errors++;
            $display("FAIL single_data: got %0d err=%b, required 12 err=0", rsp_data, rsp_err);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            checks++;
            if ({rsp0_valid, rsp1_valid, rsp_data, rsp_err} !== {1'b1, 1'b0, 8'd12, 1'b0}) begin
                errors++;
                $display("FAIL single_hold[%0d]: v0=%b v1=%b data=%0d err=%b, required 1 0 12 0", i, rsp0_valid, rsp1_valid, rsp_data, rsp_err);
            end
        end
        step();
        rsp0_ready = 1'b1;
        @(negedge clk);
        checks++;
        act.idx = rsp1_valid; act.data = rsp_data; act.err = rsp_err;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL single_sb: response %h with no expected entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e || rsp0_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_sb: got %h valid0=%b, required %h", act, rsp0_valid, e);
            end
        end
        step();
        rsp0_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            errors++;
            $display("FAIL single_release: busy=%b rsp0_valid=%b, required 0 0", busy, rsp0_valid);
        end
        step();
    endtask

    task automatic test_power();
        int who, cyc, lat, busy_bad;
        exp_t e, act;
        alu_hang = 1'b0; alu_delay = 5;
        req1_a = 4'd2; req1_b = 4'd3; req1_opcode = 3'b100; req1_valid = 1'b1;
        wait_accept_any(10, who, cyc);
        checks++;
        if (who !== 1) begin
            errors++;
            $display("FAIL power_accept: who=%0d, required 1", who);
        end
        e.idx = 1'b1; e.data = alu_ref(4'd2, 4'd3, 3'b100); e.err = 1'b0;
        sb.push_back(e);
        step();
        req1_valid = 1'b0;
        lat = -1;
        busy_bad = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (rsp1_valid === 1'b1) begin
                lat = j + 1;
                break;
            end
            step();
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL power_busy: busy low in %0d cycles, required 0", busy_bad);
        end
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL power_latency: accept to rsp1_valid %0d cycles, required 7", lat);
        end
        checks++;
        if ({rsp_data, rsp_err, rsp0_valid} !== {8'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL power_data: got %0d err=%b v0=%b, required 8 0 0", rsp_data, rsp_err, rsp0_valid);
        end
        step();
        rsp1_ready = 1'b1;
        @(negedge clk);
        checks++;
        act.idx = rsp1_valid; act.data = rsp_data; act.err = rsp_err;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL power_sb: response %h with no expected entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL power_sb: got %h, required %h", act, e);
            end
        end
        step();
        rsp1_ready = 1'b0;
        poke_req++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if ({busy, rsp0_valid, rsp1_valid, alu_start, rsp_data} !== {4'b0000, 8'd8}) begin
                errors++;
                $display("FAIL power_late_done[%0d]: busy=%b v0=%b v1=%b start=%b data=%h, required 0 0 0 0 08", j, busy, rsp0_valid, rsp1_valid, alu_start, rsp_data);
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        int who, cyc, rwho, rcyc, exp_who;
        exp_t e, act;
        alu_hang = 1'b0; alu_delay = 2;
        req0_a = 4'd5; req0_b = 4'd2; req0_opcode = 3'b000; req0_valid = 1'b1;
        req1_a = 4'd9; req1_b = 4'd4; req1_opcode = 3'b001; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_who = k % 2;
            wait_accept_any(20, who, cyc);
            checks++;
            if (who !== exp_who) begin
                errors++;
                $display("FAIL rr_grant[%0d]: granted %0d, required %0d", k, who, exp_who);
            end
            if (k > 0) begin
                checks++;
                if (cyc !== 0) begin
                    errors++;
                    $display("FAIL rr_gap[%0d]: accept %0d cycles after handshake+1, required 0", k, cyc);
                end
            end
            e.idx  = exp_who[0];
            e.data = (exp_who == 1) ? alu_ref(4'd9, 4'd4, 3'b001) : alu_ref(4'd5, 4'd2, 3'b000);
            e.err  = 1'b0;
            sb.push_back(e);
            step();
            wait_rsp_any(20, rwho, rcyc);
            checks++;
            if (rwho !== exp_who) begin
                errors++;
                $display("FAIL rr_route[%0d]: response on %0d, required %0d", k, rwho, exp_who);
            end
            checks++;
            if (rsp_data !== ((exp_who == 1) ? 8'd5 : 8'd7)) begin
                errors++;
                $display("FAIL rr_data[%0d]: got %0d, required %0d", k, rsp_data, (exp_who == 1) ? 5 : 7);
            end
            checks++;
            act.idx = rsp1_valid; act.data = rsp_data; act.err = rsp_err;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rr_sb[%0d]: response %h with no expected entry", k, act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL rr_sb[%0d]: got %h, required %h", k, act, e);
                end
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int who, cyc;
        exp_t e, act;
        alu_hang = 1'b1;
        req0_a = 4'd1; req0_b = 4'd1; req0_opcode = 3'b000; req0_valid = 1'b1;
        wait_accept_any(10, who, cyc);
        checks++;
        if (who !== 0) begin
            errors++;
            $display("FAIL timeout_accept: who=%0d, required 0", who);
        end
        e.idx = 1'b0; e.data = 8'hFF; e.err = 1'b1;
        sb.push_back(e);
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (alu_start !== 1'b1) begin
            errors++;
            $display("FAIL timeout_start: alu_start=%b, required 1", alu_start);
        end
        step();
        wait_rsp_any(60, who, cyc);
        checks++;
        if (who !== 0 || cyc !== 31) begin
            errors++;
            $display("FAIL timeout_latency: who=%0d start-to-valid=%0d, required who=0 32", who, cyc + 1);
        end
        checks++;
        if ({rsp_data, rsp_err} !== {8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL timeout_data: got %h err=%b, required FF err=1", rsp_data, rsp_err);
        end
        step();
        rsp0_ready = 1'b1;
        @(negedge clk);
        checks++;
        act.idx = rsp1_valid; act.data = rsp_data; act.err = rsp_err;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL timeout_sb: response %h with no expected entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL timeout_sb: got %h, required %h", act, e);
            end
        end
        step();
        rsp0_ready = 1'b0;
        alu_hang = 1'b0; alu_delay = 3;
        req1_a = 4'd6; req1_b = 4'd7; req1_opcode = 3'b000; req1_valid = 1'b1;
        rsp1_ready = 1'b1;
        wait_accept_any(10, who, cyc);
        checks++;
        if (who !== 1) begin
            errors++;
            $display("FAIL timeout_next_accept: who=%0d, required 1", who);
        end
        e.idx = 1'b1; e.data = alu_ref(4'd6, 4'd7, 3'b000); e.err = 1'b0;
        sb.push_back(e);
        step();
        req1_valid = 1'b0;
        wait_rsp_any(30, who, cyc);
        checks++;
        if (who !== 1 || cyc !== 4 || rsp_data !== 8'd13) begin
            errors++;
            $display("FAIL timeout_next_rsp: who=%0d offset=%0d data=%0d, required 1 4 13", who, cyc, rsp_data);
        end
        checks++;
        act.idx = rsp1_valid; act.data = rsp_data; act.err = rsp_err;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL timeout_next_sb: response %h with no expected entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL timeout_next_sb: got %h, required %h", act, e);
            end
        end
        step();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_bad_opcode();
        int who, cyc, w, s0;
        logic [2:0] op;
        exp_t e, act;
        s0 = start_count;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            w  = (k == 0) ? 1 : 0;
            op = (k == 0) ? 3'b111 : 3'b110;
            if (w == 0) begin
                req0_a = 4'd5; req0_b = 4'd5; req0_opcode = op; req0_valid = 1'b1;
            end else begin
                req1_a = 4'd2; req1_b = 4'd2; req1_opcode = op; req1_valid = 1'b1;
            end
            wait_accept_any(10, who, cyc);
            checks++;
            if (who !== w) begin
                errors++;
                $display("FAIL badop_accept[%0d]: who=%0d, required %0d", k, who, w);
            end
            e.idx = w[0]; e.data = 8'h00; e.err = 1'b1;
            sb.push_back(e);
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
            checks++;
            if ({alu_start, rsp0_valid, rsp1_valid} !== {1'b0, w == 0, w == 1}) begin
                errors++;
                $display("FAIL badop_valid[%0d]: start=%b v0=%b v1=%b, required start=0 on requester %0d", k, alu_start, rsp0_valid, rsp1_valid, w);
            end
            checks++;
            if ({rsp_data, rsp_err} !== {8'h00, 1'b1}) begin
                errors++;
                $display("FAIL badop_data[%0d]: got %h err=%b, required 00 err=1", k, rsp_data, rsp_err);
            end
            checks++;
            act.idx = rsp1_valid; act.data = rsp_data; act.err = rsp_err;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL badop_sb[%0d]: response %h with no expected entry", k, act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL badop_sb[%0d]: got %h, required %h", k, act, e);
                end
            end
            step();
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        checks++;
        if (start_count != s0) begin
            errors++;
            $display("FAIL badop_no_start: %0d start pulses, required 0", start_count - s0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int who, cyc;
        exp_t e, act;
        alu_hang = 1'b1;
        req0_a = 4'd3; req0_b = 4'd3; req0_opcode = 3'b000; req0_valid = 1'b1;
        wait_accept_any(10, who, cyc);
        checks++;
        if (who !== 0) begin
            errors++;
            $display("FAIL rstw_accept: who=%0d, required 0", who);
        end
        e.idx = 1'b0; e.data = alu_ref(4'd3, 4'd3, 3'b000); e.err = 1'b0;
        sb.push_back(e);
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_start, busy} !== 7'b0) begin
            errors++;
            $display("FAIL rstw_ctrl: got %b, required 0000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, alu_start, busy});
        end
        checks++;
        if ({rsp_data, alu_a, alu_b, alu_opcode} !== 19'd0) begin
            errors++;
            $display("FAIL rstw_data: data=%h a=%h b=%h op=%h, required 0", rsp_data, alu_a, alu_b, alu_opcode);
        end
        void'(sb.pop_back());
        step();
        req0_valid = 1'b0;
        step();
        reset = 1'b1;
        poke_req++;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++;
            if ({busy, rsp0_valid, rsp1_valid, rsp_err, rsp_data} !== 12'd0) begin
                errors++;
                $display("FAIL rstw_late_done[%0d]: busy=%b v0=%b v1=%b err=%b data=%h, required all 0", j, busy, rsp0_valid, rsp1_valid, rsp_err, rsp_data);
            end
            step();
        end
        alu_hang = 1'b0; alu_delay = 1;
        req0_a = 4'd5; req0_b = 4'd2; req0_opcode = 3'b000; req0_valid = 1'b1;
        req1_a = 4'd9; req1_b = 4'd4; req1_opcode = 3'b001; req1_valid = 1'b1;
        rsp0_ready = 1'b1;
        wait_accept_any(10, who, cyc);
        checks++;
        if (who !== 0) begin
            errors++;
            $display("FAIL rstw_tie: granted %0d, required 0", who);
        end
        e.idx = 1'b0; e.data = alu_ref(4'd5, 4'd2, 3'b000); e.err = 1'b0;
        sb.push_back(e);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp_any(20, who, cyc);
        checks++;
        if (who !== 0 || rsp_data !== 8'd7) begin
            errors++;
            $display("FAIL rstw_rsp: who=%0d data=%0d, required 0 7", who, rsp_data);
        end
        checks++;
        act.idx = rsp1_valid; act.data = rsp_data; act.err = rsp_err;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL rstw_sb: response %h with no expected entry", act);
        end else begin
            e = sb.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL rstw_sb: got %h, required %h", act, e);
            end
        end
        step();
        rsp0_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_power();
        test_round_robin();
        test_timeout();
        test_bad_opcode();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the sequence completed");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
